result_readout: RTL and testbench
=================================

# result_readout

Capture-and-return stage directly downstream of the matrix controller and systolic array. During the array's READ phase it captures one accumulated result per cycle into a local buffer, saturates each to the SPI word size, and streams the words back to the SPI transmit side when the host issues a READ_RESULT command. It also decodes the command from the SPI receive bus, closing the host → compute → host loop.

## Interface
- WORD_SIZE, 16, width of SPI words and of returned results
- ACC_SIZE, 32, signed width of array accumulator results
- DEPTH, 64, buffer entries; equals PE count
- READ_RESULT, 4'h6, opcode in cmd_data[15:12] that starts readout
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- read  in  1  controller READ phase strobe; one result per high cycle
- res_data  in  ACC_SIZE  signed result, valid on cycles where read=1
- cmd_valid  in  1  SPI receive word valid; asynchronous to clk
- cmd_data  in  WORD_SIZE  SPI receive word, stable while cmd_valid high
- tx_valid  out  1  word available on tx_data
- tx_data  out  WORD_SIZE  returned result word
- tx_ready  in  1  SPI transmit side accepts tx_data this cycle
- result_avail  out  1  buffer holds an unread result set
- overflow  out  1  sticky: capture exceeded DEPTH or arrived during SEND

## Operation
- States: IDLE, CAPTURE, HOLD, SEND.
- IDLE: read=1 → CAPTURE; the first word is written in this same cycle at index 0, and the write pointer becomes 1.
- CAPTURE: each read=1 cycle writes sat(res_data) at wr_ptr and increments wr_ptr. When read falls, latch count=wr_ptr, set result_avail, and go to HOLD.
- Writes with wr_ptr=DEPTH are dropped and set overflow. count stays at DEPTH.
- HOLD: a command edge with cmd_data[15:12]=READ_RESULT → SEND with rd_ptr=0. All other opcodes are ignored.
- A new read=1 in HOLD discards the old set and restarts CAPTURE at index 0. result_avail drops in that cycle.
- SEND: tx_valid=1 and tx_data=buf[rd_ptr]. On tx_valid & tx_ready, rd_ptr increments. After the word at count-1 is accepted: clear result_avail and go to IDLE.
- read=1 during SEND is ignored and sets overflow. The send continues.
- A READ_RESULT edge in IDLE, CAPTURE or SEND is ignored; no tx_valid results.
- overflow clears only on reset or on entry to CAPTURE from IDLE.
- Saturation:
  - res_data > 2^(WORD_SIZE-1)-1 → 16'h7FFF
  - res_data < -2^(WORD_SIZE-1) → 16'h8000
  - otherwise truncate to the low WORD_SIZE bits.
- Pointers are $clog2(DEPTH)+1 bits. count never wraps.

## Timing
- Reset values: tx_valid=0, tx_data=0, result_avail=0, overflow=0, state=IDLE, pointers and count=0. The buffer contents are not reset.
- Command path: cmd_valid passes through a 2-flop synchronizer, then a rising-edge detect on sync[1] & ~sync[2]. cmd_data is sampled on the detect cycle.
- Latency: a READ_RESULT edge is detected 2–3 clk after cmd_valid rises. The state is SEND and tx_valid=1 on the cycle after detect.
- Handshake:
  - tx_data is registered and changes only on the cycle after acceptance.
  - tx_valid must not drop without acceptance.
  - tx_ready may be held high; the block then sustains one word per cycle.
- result_avail rises on the cycle after read falls.
- Asserting rst_n low mid-SEND or mid-CAPTURE returns all outputs to reset values immediately, with no further tx handshakes.

## Structure
- Package matrix_pkg: typedef state_e {IDLE, CAPTURE, HOLD, SEND}, opcode constants (READ_RESULT and its siblings), and function sat_word(ACC_SIZE→WORD_SIZE).
- Sub-module cmd_sync_edge (2-flop synchronizer plus rising-edge detect). It is reused by other SPI-facing blocks.
- Buffer: single-port register array, WORD_SIZE×DEPTH. One write path and one registered read path; never both used in the same state.

## Test plan
- 4 read cycles with res_data 5, -3, 40000, -40000 → READ_RESULT with tx_ready=1 → tx_data 0x0005, 0xFFFD, 0x7FFF, 0x8000 on consecutive cycles, then result_avail=0.
- Same capture, tx_ready toggled 1-0-0-1-1-0-1 → tx_data held while tx_valid & !tx_ready; exactly 4 accepted words, in order.
- 66 read cycles with DEPTH=64 → overflow=1, 64 words returned; last word = sat of the 64th result.
- READ_RESULT in IDLE, and opcode 4'h4 in HOLD → tx_valid stays 0; a later 4'h6 edge returns the stored set.
- read pulse of 2 cycles during SEND → overflow=1; the remaining words of the original set are unchanged.
- rst_n low for 1 cycle at the 3rd accepted word of a 4-word send → tx_valid=0, result_avail=0 immediately; a subsequent READ_RESULT produces no output.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types, opcodes and helpers for the matrix accelerator's SPI-facing blocks.
package matrix_pkg;

    localparam int MAT_WORD_SIZE = 16;
    localparam int MAT_ACC_SIZE  = 32;
    localparam int MAT_DEPTH     = 64;

    // Host command opcodes carried in the top nibble of an SPI word
    localparam logic [3:0] OP_NOP          = 4'h0;
    localparam logic [3:0] OP_LOAD_WEIGHTS = 4'h1;
    localparam logic [3:0] OP_LOAD_INPUTS  = 4'h2;
    localparam logic [3:0] OP_START        = 4'h3;
    localparam logic [3:0] OP_STATUS       = 4'h4;
    localparam logic [3:0] OP_CLEAR        = 4'h5;
    localparam logic [3:0] OP_READ_RESULT  = 4'h6;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD,
        SEND
    } state_e;

    localparam logic signed [MAT_ACC_SIZE-1:0] SAT_MAX =
        MAT_ACC_SIZE'((64'sd1 <<< (MAT_WORD_SIZE - 1)) - 64'sd1);
    localparam logic signed [MAT_ACC_SIZE-1:0] SAT_MIN =
        MAT_ACC_SIZE'(-(64'sd1 <<< (MAT_WORD_SIZE - 1)));

    // Clamp a signed accumulator to the signed SPI word range
    function automatic logic [MAT_WORD_SIZE-1:0] sat_word(input logic signed [MAT_ACC_SIZE-1:0] acc);
        if (acc > SAT_MAX) begin
            sat_word = {1'b0, {(MAT_WORD_SIZE - 1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            sat_word = {1'b1, {(MAT_WORD_SIZE - 1){1'b0}}};
        end else begin
            sat_word = acc[MAT_WORD_SIZE-1:0];
        end
    endfunction

endpackage

// File: rtl/cmd_sync_edge.sv
// Two-flop synchronizer for an asynchronous strobe followed by a one-cycle
// rising-edge pulse in the clk domain.
module cmd_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], sig};
        end
    end

    assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/result_readout.sv
// Captures saturated array results during the READ phase and streams them
// back to the SPI transmit side on a READ_RESULT command.
module result_readout
    import matrix_pkg::*;
#(
    parameter int         WORD_SIZE   = MAT_WORD_SIZE,
    parameter int         ACC_SIZE    = MAT_ACC_SIZE,
    parameter int         DEPTH       = MAT_DEPTH,
    parameter logic [3:0] READ_RESULT = OP_READ_RESULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 read,
    input  logic [ACC_SIZE-1:0]  res_data,
    input  logic                 cmd_valid,
    input  logic [WORD_SIZE-1:0] cmd_data,
    output logic                 tx_valid,
    output logic [WORD_SIZE-1:0] tx_data,
    input  logic                 tx_ready,
    output logic                 result_avail,
    output logic                 overflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

    state_e state, state_next;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, count;
    logic [IDX_W-1:0]     wr_idx, rd_idx_next;
    logic [WORD_SIZE-1:0] wr_word;

    logic cmd_rise, read_cmd, accept, last_word;
    logic wr_en, restart, wr_drop, load_first, close_set, late_read;
    logic cmd_unused;

    cmd_sync_edge u_cmd_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (cmd_valid),
        .rise (cmd_rise)
    );

    assign cmd_unused  = ^cmd_data[WORD_SIZE-5:0];
    assign read_cmd    = cmd_rise && (cmd_data[WORD_SIZE-1 -: 4] == READ_RESULT);
    assign accept      = tx_valid && tx_ready;
    assign last_word   = (rd_ptr == count - PTR_W'(1));
    assign wr_word     = sat_word(res_data);
    assign wr_idx      = restart ? '0 : wr_ptr[IDX_W-1:0];
    assign wr_drop     = wr_en && !restart && (wr_ptr == FULL);
    assign rd_idx_next = rd_ptr[IDX_W-1:0] + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A fresh READ phase in HOLD wins over a simultaneous READ_RESULT edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read) state_next = CAPTURE;
            CAPTURE: if (!read) state_next = HOLD;
            HOLD: begin
                if (read) begin
                    state_next = CAPTURE;
                end else if (read_cmd) begin
                    state_next = SEND;
                end
            end
            SEND:    if (accept && last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_valid   = 1'b0;
        wr_en      = 1'b0;
        restart    = 1'b0;
        load_first = 1'b0;
        close_set  = 1'b0;
        late_read  = 1'b0;
        case (state)
            IDLE: begin
                wr_en   = read;
                restart = read;
            end
            CAPTURE: begin
                wr_en     = read;
                close_set = !read;
            end
            HOLD: begin
                wr_en      = read;
                restart    = read;
                load_first = !read && read_cmd;
            end
            SEND: begin
                tx_valid  = 1'b1;
                late_read = read;
            end
            default: ;
        endcase
    end

    // Buffer contents survive reset; only the pointers describe validity
    always_ff @(posedge clk) begin
        if (wr_en && !wr_drop) begin
            mem[wr_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tx_data      <= '0;
            result_avail <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (restart) begin
                wr_ptr <= PTR_W'(1);
            end else if (wr_en && !wr_drop) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (state == IDLE && read) begin
                overflow <= 1'b0;
            end else if (wr_drop || late_read) begin
                overflow <= 1'b1;
            end

            if (close_set) begin
                count        <= wr_ptr;
                result_avail <= 1'b1;
            end else if (restart || (accept && last_word)) begin
                result_avail <= 1'b0;
            end

            if (load_first) begin
                rd_ptr  <= '0;
                tx_data <= mem[IDX_W'(0)];
            end else if (accept && !last_word) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                tx_data <= mem[rd_idx_next];
            end
        end
    end

endmodule

// File: tb/tb_result_readout.sv
// Randomized self-checking bench for result_readout against a queue-based
// model of the captured result set.
module tb_result_readout;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        read;
    logic [31:0] res_data;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;
    logic        result_avail;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    int          stim[$];
    logic [15:0] exp_q[$];
    bit          model_hold  = 0;
    bit          model_avail = 0;
    bit          model_ovf   = 0;

    result_readout dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read        (read),
        .res_data    (res_data),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .result_avail(result_avail),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] satRef(input int v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic int randVal();
        int edges[4];
        edges = '{32767, 32768, -32768, -32769};
        case ($urandom_range(0, 5))
            0:       return int'($urandom_range(0, 200)) - 100;
            1:       return 32768 + int'($urandom_range(0, 1000000));
            2:       return -32769 - int'($urandom_range(0, 1000000));
            3:       return int'($urandom());
            4:       return edges[$urandom_range(0, 3)];
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    // Drive one READ burst from stim and update the model's result set
    task automatic applyStimulus();
        if (!model_hold) model_ovf = 0;
        exp_q.delete();
        foreach (stim[i]) begin
            @(negedge clk);
            read     = 1'b1;
            res_data = stim[i];
            if (exp_q.size() < DEPTH) exp_q.push_back(satRef(stim[i]));
            else model_ovf = 1;
        end
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        model_hold  = 1;
        model_avail = 1;
        checkOutput("cap_avail", result_avail, model_avail);
        checkOutput("cap_ovf", overflow, model_ovf);
        checkOutput("cap_txvalid", tx_valid, 0);
    endtask

    task automatic sendCmd(input logic [3:0] op);
        bit expect_send;
        bit seen;
        int first;
        expect_send = model_hold && (op == 4'h6);
        seen  = 0;
        first = -1;
        @(negedge clk);
        tx_ready  = 1'b0;
        cmd_data  = {op, 12'($urandom())};
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_valid && !seen) first = i;
            if (tx_valid) seen = 1;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        checkOutput(expect_send ? "send_start" : "no_send", seen, expect_send);
        if (expect_send) begin
            checkOutput("send_latency", (first >= 2 && first <= 3), 1);
            checkOutput("send_avail", result_avail, 1);
            model_hold = 0;
        end
    endtask

    // Accept words with a ready pattern; optional read pulse or reset mid-send
    task automatic drain(input int mode, input int inject_at, input int reset_at);
        bit          pat[7];
        bit          r, v, prev_hold, injected;
        logic [15:0] d, prev_d;
        int          got, step, read_left;
        pat       = '{1, 0, 0, 1, 1, 0, 1};
        got       = 0;
        step      = 0;
        read_left = 0;
        prev_hold = 0;
        prev_d    = '0;
        injected  = 0;
        while (exp_q.size() != 0 && step < 500) begin
            @(negedge clk);
            v = tx_valid;
            d = tx_data;
            checkOutput("send_valid", v, 1);
            if (!v) break;
            if (prev_hold) checkOutput("hold_data", d, prev_d);
            if (got == reset_at) begin
                rst_n    = 1'b0;
                tx_ready = 1'b1;
                #1;
                checkOutput("rst_txvalid", tx_valid, 0);
                checkOutput("rst_txdata", tx_data, 0);
                checkOutput("rst_avail", result_avail, 0);
                checkOutput("rst_ovf", overflow, 0);
                @(posedge clk);
                #1;
                checkOutput("rst_hold_txvalid", tx_valid, 0);
                @(negedge clk);
                rst_n     = 1'b1;
                tx_ready  = 1'b0;
                read      = 1'b0;
                exp_q.delete();
                model_hold  = 0;
                model_avail = 0;
                model_ovf   = 0;
                return;
            end
            case (mode)
                0:       r = 1;
                1:       r = pat[step % 7];
                default: r = 1'($urandom_range(0, 1));
            endcase
            step++;
            tx_ready = r;
            if (r) begin
                checkOutput("word", d, exp_q.pop_front());
                got++;
            end
            prev_hold = !r;
            prev_d    = d;
            if (inject_at >= 0 && got == inject_at && !injected) begin
                injected  = 1;
                read_left = 2;
                model_ovf = 1;
            end
            read = (read_left > 0);
            if (read_left > 0) read_left--;
        end
        checkOutput("drain_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        tx_ready    = 1'b0;
        read        = 1'b0;
        model_avail = 0;
        checkOutput("end_txvalid", tx_valid, 0);
        checkOutput("end_avail", result_avail, model_avail);
        checkOutput("end_ovf", overflow, model_ovf);
    endtask

    initial begin
        logic [3:0] op;
        rst_n     = 1'b0;
        read      = 1'b0;
        res_data  = '0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        tx_ready  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_txvalid", tx_valid, 0);
        checkOutput("reset_txdata", tx_data, 0);
        checkOutput("reset_avail", result_avail, 0);
        checkOutput("reset_ovf", overflow, 0);
        rst_n = 1'b1;

        $display("[TB] READ_RESULT while idle");
        sendCmd(4'h6);

        $display("[TB] basic saturation readout, ready held high");
        stim = '{5, -3, 40000, -40000};
        applyStimulus();
        sendCmd(4'h4);
        checkOutput("op4_avail", result_avail, 1);
        sendCmd(4'h6);
        drain(0, -1, -1);

        $display("[TB] same capture, toggled ready");
        applyStimulus();
        sendCmd(4'h6);
        drain(1, -1, -1);

        $display("[TB] 66-cycle capture overflow");
        stim.delete();
        for (int i = 0; i < 66; i++) stim.push_back(randVal());
        applyStimulus();
        sendCmd(4'h6);
        drain(0, -1, -1);

        $display("[TB] read pulse during send");
        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back(randVal());
        applyStimulus();
        sendCmd(4'h6);
        drain(0, 1, -1);

        $display("[TB] reset at third accepted word");
        stim.delete();
        for (int i = 0; i < 4; i++) stim.push_back(randVal());
        applyStimulus();
        sendCmd(4'h6);
        drain(0, -1, 2);
        sendCmd(4'h6);

        $display("[TB] randomized sets");
        for (int iter = 0; iter < 8; iter++) begin
            stim.delete();
            for (int i = 0; i < $urandom_range(1, 70); i++) stim.push_back(randVal());
            applyStimulus();
            if ($urandom_range(0, 2) == 0) begin
                stim.delete();
                for (int i = 0; i < $urandom_range(1, 70); i++) stim.push_back(randVal());
                applyStimulus();
            end
            op = 4'($urandom_range(0, 15));
            if (op == 4'h6) op = 4'h4;
            sendCmd(op);
            sendCmd(4'h6);
            drain(2, (exp_q.size() > 4) ? 1 : -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
